// File: rtl/qoa_spi_slave_fifo.sv
// SPI slave, CPOL/CPHA modes 0-3, pins oversampled in the sclk domain, RX FIFO.
// QOA_SPI_TXFIFO_EN selects a DEPTH-entry TX FIFO instead of a holding register.
module qoa_spi_slave_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             rx_overflow,
  output logic             tx_underrun,
  input  logic             flag_clr,
  output logic             frame_abort,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [1:0] sck_s, cs_s, mosi_s;
  logic       sck_d, cs_d;

  // cs flops reset to "asserted" so a CS held low across reset is not a new frame
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      sck_s  <= '0;
      sck_d  <= 1'b0;
      cs_s   <= '0;
      cs_d   <= 1'b0;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[0], spi_sck};
      sck_d  <= sck_s[1];
      cs_s   <= {cs_s[0], spi_cs_n};
      cs_d   <= cs_s[1];
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  end

  logic sck_r, sck_f, cs_fall, cs_rise;

  assign sck_r   = sck_s[1] & ~sck_d;
  assign sck_f   = ~sck_s[1] & sck_d;
  assign cs_fall = ~cs_s[1] & cs_d;
  assign cs_rise = cs_s[1] & ~cs_d;

  always_ff @(posedge sclk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [1:0]       mode_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic             done_q;

  logic act, cpol, cpha, lead, trail, smp, sft;
  logic start, stop, word_end, tx_load;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] tx_head;
  logic             tx_empty;

  assign act      = (state_q == ACTIVE);
  assign cpol     = mode_q[1];
  assign cpha     = mode_q[0];
  assign lead     = cpol ? sck_f : sck_r;
  assign trail    = cpol ? sck_r : sck_f;
  assign smp      = act & (cpha ? trail : lead);
  assign sft      = act & (cpha ? lead : trail);
  assign start    = (state_q == IDLE) & cs_fall;
  assign stop     = act & cs_rise;
  assign word_end = smp & (cnt == CW'(WIDTH - 1));
  assign rx_word  = {rx_sr, mosi_s[1]};

  // CPHA=0 needs the MSB out before the first edge; CPHA=1 loads on it
  assign tx_load = (start & ~mode[0])
                 | (sft & ~cpha & done_q)
                 | (sft & cpha & (cnt == '0));

  assign spi_miso    = tx_sr[WIDTH-1];
  assign spi_miso_oe = act;
  assign busy        = act;

  logic [AW:0]      rwp, rrp;
  logic [WIDTH-1:0] rmem [DEPTH];
  logic             rx_full, rx_empty, rx_pop, rx_wr, ovf_set, unr_set;

  assign rx_empty = (rwp == rrp);
  assign rx_full  = (rwp[AW] != rrp[AW]) && (rwp[AW-1:0] == rrp[AW-1:0]);
  assign rx_pop   = ~rx_empty & rx_ready;
  assign rx_wr    = word_end & (~rx_full | rx_pop);
  assign ovf_set  = word_end & rx_full & ~rx_pop;
  assign unr_set  = tx_load & tx_empty;
  assign rx_valid = ~rx_empty;
  assign rx_data  = rmem[rrp[AW-1:0]];

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      rwp <= '0;
      rrp <= '0;
    end else begin
      if (rx_wr)  rwp <= rwp + 1'b1;
      if (rx_pop) rrp <= rrp + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (rx_wr) rmem[rwp[AW-1:0]] <= rx_word;
  end

`ifdef QOA_SPI_TXFIFO_EN
  logic [AW:0]      twp, trp;
  logic [WIDTH-1:0] tmem [DEPTH];
  logic             tx_full, tx_push, tx_pop;

  assign tx_empty = (twp == trp);
  assign tx_full  = (twp[AW] != trp[AW]) && (twp[AW-1:0] == trp[AW-1:0]);
  assign tx_push  = tx_valid & ~tx_full;
  assign tx_pop   = tx_load & ~tx_empty;
  assign tx_ready = ~tx_full;
  assign tx_head  = tmem[trp[AW-1:0]];

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      twp <= '0;
      trp <= '0;
    end else begin
      if (tx_push) twp <= twp + 1'b1;
      if (tx_pop)  trp <= trp + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (tx_push) tmem[twp[AW-1:0]] <= tx_data;
  end
`else
  logic [WIDTH-1:0] thold;
  logic             thold_v;

  assign tx_empty = ~thold_v;
  assign tx_ready = ~thold_v;
  assign tx_head  = thold;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      thold_v <= 1'b0;
      thold   <= '0;
    end else if (tx_valid & ~thold_v) begin
      thold_v <= 1'b1;
      thold   <= tx_data;
    end else if (tx_load & thold_v) begin
      thold_v <= 1'b0;
    end
  end
`endif

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      mode_q      <= '0;
      cnt         <= '0;
      rx_sr       <= '0;
      done_q      <= 1'b0;
      tx_sr       <= '0;
      frame_abort <= 1'b0;
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      frame_abort <= stop & (cnt != '0);
      if (start) begin
        mode_q <= mode;
        cnt    <= '0;
        done_q <= 1'b0;
      end else if (stop) begin
        cnt    <= '0;
        done_q <= 1'b0;
      end else if (smp) begin
        rx_sr <= rx_word[WIDTH-2:0];
        if (word_end) begin
          cnt    <= '0;
          done_q <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (tx_load) begin
        done_q <= 1'b0;
      end
      if (stop)         tx_sr <= '0;
      else if (tx_load) tx_sr <= tx_empty ? '0 : tx_head;
      else if (sft)     tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      if (ovf_set)       rx_overflow <= 1'b1;
      else if (flag_clr) rx_overflow <= 1'b0;
      if (unr_set)       tx_underrun <= 1'b1;
      else if (flag_clr) tx_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qoa_spi_slave_fifo.sv
// Bench for qoa_spi_slave_fifo: bit-banged SPI master with RX/TX scoreboards.
// Builds with or without QOA_SPI_TXFIFO_EN.
module tb_qoa_spi_slave_fifo;
  localparam int W = 8;
  localparam int D = 4;
  localparam int H = 8;
`ifdef QOA_SPI_TXFIFO_EN
  localparam int TXCAP = D;
`else
  localparam int TXCAP = 1;
`endif

  logic         sclk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         spi_sck = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso, spi_miso_oe;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         rx_overflow, tx_underrun;
  logic         flag_clr = 1'b0;
  logic         frame_abort, busy;

  qoa_spi_slave_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .sclk(sclk), .rst_n(rst_n), .mode(mode),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
    .flag_clr(flag_clr), .frame_abort(frame_abort), .busy(busy)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_errors = 0;
  int abort_cycles = 0;

  logic [W-1:0] rx_q[$];
  logic [W-1:0] tx_model[$];
  logic [W-1:0] miso_q[$];
  logic [W-1:0] mosi_words [8];
  logic         exp_ovf = 1'b0;
  logic         exp_unr = 1'b0;

  always @(posedge sclk) if (frame_abort) abort_cycles <= abort_cycles + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " miso"}, spi_miso, 0);
    check({tag, " oe"}, spi_miso_oe, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " rx_valid"}, rx_valid, 0);
    check({tag, " ovf"}, rx_overflow, 0);
    check({tag, " unr"}, tx_underrun, 0);
    check({tag, " abort"}, frame_abort, 0);
    check({tag, " tx_ready"}, tx_ready, 1);
  endtask

  task automatic tx_push(input logic [W-1:0] d);
    logic rdy;
    rdy = (tx_model.size() < TXCAP);
    check("tx_ready", tx_ready, rdy);
    tx_valid = 1'b1;
    tx_data  = d;
    if (rdy) tx_model.push_back(d);
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic flags_clear();
    flag_clr = 1'b1;
    cyc(1);
    flag_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_unr = 1'b0;
  endtask

  task automatic xfer(input logic [1:0] m, input int nw, input int part);
    logic         cpol, cpha;
    logic [W-1:0] got;
    int           loads, wi, bi;
    cpol = m[1];
    cpha = m[0];
    got = '0;
    loads = cpha ? nw + ((part > 0) ? 1 : 0) : nw + 1;
    miso_q.delete();
    for (int i = 0; i < loads; i++) begin
      if (tx_model.size() > 0) miso_q.push_back(tx_model.pop_front());
      else begin
        miso_q.push_back('0);
        exp_unr = 1'b1;
      end
    end
    for (int i = 0; i < nw; i++) begin
      if (rx_q.size() < D) rx_q.push_back(mosi_words[i]);
      else exp_ovf = 1'b1;
    end
    mode = m;
    spi_sck = cpol;
    cyc(8);
    spi_cs_n = 1'b0;
    cyc(8);
    check("busy act", busy, 1);
    check("oe act", spi_miso_oe, 1);
    for (int b = 0; b < nw * W + part; b++) begin
      wi = b / W;
      bi = W - 1 - (b % W);
      if (!cpha) begin
        spi_mosi = mosi_words[wi][bi];
        cyc(H);
        got = {got[W-2:0], spi_miso};
        spi_sck = ~cpol;
        cyc(H);
        spi_sck = cpol;
      end else begin
        spi_sck = ~cpol;
        spi_mosi = mosi_words[wi][bi];
        cyc(H);
        got = {got[W-2:0], spi_miso};
        spi_sck = cpol;
        cyc(H);
      end
      if ((b % W) == W - 1)
        check($sformatf("miso m%0d w%0d", m, wi), got, miso_q[wi]);
    end
    cyc(H);
    spi_cs_n = 1'b1;
    cyc(8);
    check("busy idle", busy, 0);
    check("miso idle", spi_miso, 0);
    check("oe idle", spi_miso_oe, 0);
    check("overflow", rx_overflow, exp_ovf);
    check("underrun", tx_underrun, exp_unr);
  endtask

  task automatic rx_drain(input string tag);
    for (int i = 0; i < D + 2; i++) begin
      if (!rx_valid) break;
      if (rx_q.size() == 0) check({tag, " extra"}, 1, 0);
      else check(tag, rx_data, rx_q.pop_front());
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
    end
    check({tag, " missing"}, rx_q.size(), 0);
    check({tag, " empty"}, rx_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    int base;
    cyc(4);
    check_reset("reset");
    rst_n = 1'b1;
    cyc(4);

    tx_push(8'hA5);
    mosi_words[0] = 8'h3C;
    xfer(2'd0, 1, 0);
    rx_drain("m0 rx");

    for (int m = 1; m < 4; m++) begin
      flags_clear();
      tx_push(8'h5A);
      mosi_words[0] = 8'hC3;
      xfer(2'(m), 1, 0);
      rx_drain($sformatf("m%0d rx", m));
    end

    flags_clear();
    for (int i = 0; i < 5; i++) mosi_words[i] = 8'(8'h11 * (i + 1));
    xfer(2'd0, 5, 0);
    check("ovf rx_valid", rx_valid, 1);
    rx_drain("ovf rx");
    flags_clear();
    check("ovf clr", rx_overflow, exp_ovf);
    check("unr clr", tx_underrun, exp_unr);

    mosi_words[0] = 8'h81;
    mosi_words[1] = 8'h7E;
    xfer(2'd0, 2, 0);
    rx_drain("unr rx");

    flags_clear();
    base = abort_cycles;
    mosi_words[0] = 8'hFF;
    xfer(2'd0, 0, 5);
    check("abort pulse", abort_cycles - base, 1);
    check("abort no push", rx_valid, 0);
    tx_push(8'h3C);
    mosi_words[0] = 8'h96;
    xfer(2'd0, 1, 0);
    check("abort after full", abort_cycles - base, 1);
    rx_drain("post abort rx");
    flags_clear();
    mosi_words[0] = 8'h00;
    xfer(2'd3, 0, 3);
    check("abort m3", abort_cycles - base, 2);

    flags_clear();
    tx_push(8'h11);
    tx_push(8'h22);
    mosi_words[0] = 8'h5C;
    xfer(2'd1, 1, 0);
    rx_drain("hold rx");

    mosi_words[0] = 8'hA1;
    mosi_words[1] = 8'hB2;
    xfer(2'd0, 2, 0);
    check("queued", rx_valid, 1);
    tx_push(8'h33);
    mode = 2'd0;
    spi_sck = 1'b0;
    cyc(8);
    spi_cs_n = 1'b0;
    cyc(8);
    spi_mosi = 1'b1;
    cyc(H);
    spi_sck = 1'b1;
    cyc(H);
    spi_sck = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    check_reset("midrst");
    rst_n = 1'b1;
    rx_q.delete();
    tx_model.delete();
    exp_ovf = 1'b0;
    exp_unr = 1'b0;
    cyc(10);
    check("stay idle", busy, 0);
    check("stay idle rx", rx_valid, 0);
    spi_cs_n = 1'b1;
    cyc(8);
    check("idle after cs", busy, 0);
    tx_push(8'h69);
    mosi_words[0] = 8'hE7;
    xfer(2'd1, 1, 0);
    rx_drain("post rst rx");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
